// File: rtl/nn_wb_sched_pkg.sv
// Shared widths and state encoding for the result write-back scheduler.
// Imported by the scheduler top and its nested pe/addr counter.
package nn_wb_sched_pkg;

    localparam int PE_NUM          = 16;
    localparam int PE_SEL_WIDTH    = 4;
    localparam int PMEM_ADDR_WIDTH = 8;
    localparam int OUT_WIDTH       = 16;
    localparam int DMA_ADDR_WIDTH  = 32;
    localparam int DMA_DATA_WIDTH  = 2 * OUT_WIDTH;

    localparam int CNT_W = PMEM_ADDR_WIDTH + 1;
    localparam int ACT_W = PE_SEL_WIDTH + 1;

    localparam logic [ACT_W-1:0] PE_NUM_W = ACT_W'(PE_NUM);

    typedef enum logic [2:0] {
        WB_IDLE = 3'd0,
        WB_RD   = 3'd1,
        WB_WAIT = 3'd2,
        WB_WR   = 3'd3,
        WB_DONE = 3'd4
    } wb_state_t;

    function automatic logic [ACT_W-1:0] clamp_pe_act(
        input logic [ACT_W-1:0] n
    );
        return (n > PE_NUM_W) ? PE_NUM_W : n;
    endfunction

endpackage

// File: rtl/nn_wb_cnt.sv
// Nested pe/addr walk counter for the write-back scheduler.
// Address is the inner loop; terminal flags drive the FSM exit.
module nn_wb_cnt
    import nn_wb_sched_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       adv,
    input  logic [CNT_W-1:0]           count,
    input  logic [ACT_W-1:0]           pe_act,
    output logic [PE_SEL_WIDTH-1:0]    pe,
    output logic [PMEM_ADDR_WIDTH-1:0] addr,
    output logic                       last_addr,
    output logic                       last_word
);

    // Terminal conditions against the latched job shape
    always_comb begin
        last_addr = ({1'b0, addr} == (count - CNT_W'(1)));
        last_word = last_addr && ({1'b0, pe} == (pe_act - ACT_W'(1)));
    end

    // Advance one word per accepted DMA write; wrap to 0 after the job
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe   <= '0;
            addr <= '0;
        end else if (clr) begin
            pe   <= '0;
            addr <= '0;
        end else if (adv) begin
            if (last_word) begin
                pe   <= '0;
                addr <= '0;
            end else if (last_addr) begin
                pe   <= pe + PE_SEL_WIDTH'(1);
                addr <= '0;
            end else begin
                addr <= addr + PMEM_ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/nn_wb_sched.sv
// Result write-back scheduler: walks PEs and pmem entries,
// packs both banks into one DMA word and issues handshaked writes.
module nn_wb_sched
    import nn_wb_sched_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_start,
    input  logic                       i_abort,
    input  logic [DMA_ADDR_WIDTH-1:0]  i_base_addr,
    input  logic [CNT_W-1:0]           i_count,
    input  logic [ACT_W-1:0]           i_pe_act,
    input  logic [OUT_WIDTH-1:0]       i_pmem_rd_data0,
    input  logic [OUT_WIDTH-1:0]       i_pmem_rd_data1,
    input  logic                       i_dma_wr_ready,
    output logic [PE_SEL_WIDTH-1:0]    o_pe_sel,
    output logic                       o_pmem_rd_en0,
    output logic                       o_pmem_rd_en1,
    output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_rd_addr0,
    output logic [PMEM_ADDR_WIDTH-1:0] o_pmem_rd_addr1,
    output logic                       o_dma_wr_en,
    output logic [DMA_ADDR_WIDTH-1:0]  o_dma_wr_addr,
    output logic [DMA_DATA_WIDTH-1:0]  o_dma_wr_data,
    output logic                       o_busy,
    output logic                       o_finish
);

    wb_state_t                   state_q;
    wb_state_t                   state_d;
    logic [CNT_W-1:0]            cnt_q;
    logic [ACT_W-1:0]            act_q;
    logic [DMA_ADDR_WIDTH-1:0]   wr_addr_q;
    logic [DMA_DATA_WIDTH-1:0]   wr_data_q;
    logic [PE_SEL_WIDTH-1:0]     pe;
    logic [PMEM_ADDR_WIDTH-1:0]  addr;
    logic                        last_addr;
    logic                        last_word;
    logic                        launch;
    logic                        abort;
    logic                        accept;

    assign launch = (state_q == WB_IDLE) && i_start;
    assign abort  = (state_q != WB_IDLE) && i_abort;
    assign accept = (state_q == WB_WR) && i_dma_wr_ready;

    nn_wb_cnt u_cnt (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .clr       (launch || abort),
        .adv       (accept && !abort),
        .count     (cnt_q),
        .pe_act    (act_q),
        .pe        (pe),
        .addr      (addr),
        .last_addr (last_addr),
        .last_word (last_word)
    );

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= WB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and Moore outputs; abort overrides any transition
    always_comb begin
        state_d         = state_q;
        o_pe_sel        = '0;
        o_pmem_rd_en0   = 1'b0;
        o_pmem_rd_addr0 = '0;
        o_dma_wr_en     = 1'b0;
        o_finish        = 1'b0;
        case (state_q)
            WB_IDLE: begin
                if (i_start) begin
                    if (i_count == '0 || i_pe_act == '0) begin
                        state_d = WB_DONE;
                    end else begin
                        state_d = WB_RD;
                    end
                end
            end
            WB_RD: begin
                o_pe_sel        = pe;
                o_pmem_rd_en0   = 1'b1;
                o_pmem_rd_addr0 = addr;
                state_d         = WB_WAIT;
            end
            WB_WAIT: begin
                o_pe_sel = pe;
                state_d  = WB_WR;
            end
            WB_WR: begin
                o_pe_sel    = pe;
                o_dma_wr_en = 1'b1;
                if (i_dma_wr_ready) begin
                    state_d = last_word ? WB_DONE : WB_RD;
                end
            end
            WB_DONE: begin
                o_finish = 1'b1;
                state_d  = WB_IDLE;
            end
            default: begin
                state_d = WB_IDLE;
            end
        endcase
        if (abort) begin
            state_d = WB_IDLE;
        end
    end

    assign o_pmem_rd_en1   = o_pmem_rd_en0;
    assign o_pmem_rd_addr1 = o_pmem_rd_addr0;
    assign o_busy          = (state_q != WB_IDLE);
    assign o_dma_wr_addr   = wr_addr_q;
    assign o_dma_wr_data   = wr_data_q;

    // Latch job shape at launch, clamping the PE count to the array size
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
            act_q <= '0;
        end else if (launch) begin
            cnt_q <= i_count;
            act_q <= clamp_pe_act(i_pe_act);
        end
    end

    // Write address and packed data, held stable while WR waits on ready
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            if (launch) begin
                wr_addr_q <= i_base_addr;
            end else if (accept && !abort) begin
                wr_addr_q <= wr_addr_q + DMA_ADDR_WIDTH'(4);
            end
            if (state_q == WB_WAIT) begin
                wr_data_q <= {i_pmem_rd_data1, i_pmem_rd_data0};
            end
        end
    end

endmodule

// File: tb/tb_nn_wb_sched.sv
// Directed self-checking bench for nn_wb_sched.
// A behavioural pmem returns {pe,addr} patterns with 1-cycle latency.
module tb_nn_wb_sched;
    import nn_wb_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] base_addr;
    logic [8:0]  count_in;
    logic [4:0]  pe_act_in;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        ready;
    logic [3:0]  pe_sel;
    logic        rd_en0;
    logic        rd_en1;
    logic [7:0]  rd_addr0;
    logic [7:0]  rd_addr1;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        finish;

    int checks = 0;
    int failures = 0;
    int wr_n, en_n, rd_n, fin_n, max_pe;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    int fin_cyc, busy_n, stable_n;

    always #5 clk = ~clk;

    nn_wb_sched dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_start         (start),
        .i_abort         (abort),
        .i_base_addr     (base_addr),
        .i_count         (count_in),
        .i_pe_act        (pe_act_in),
        .i_pmem_rd_data0 (d0),
        .i_pmem_rd_data1 (d1),
        .i_dma_wr_ready  (ready),
        .o_pe_sel        (pe_sel),
        .o_pmem_rd_en0   (rd_en0),
        .o_pmem_rd_en1   (rd_en1),
        .o_pmem_rd_addr0 (rd_addr0),
        .o_pmem_rd_addr1 (rd_addr1),
        .o_dma_wr_en     (wr_en),
        .o_dma_wr_addr   (wr_addr),
        .o_dma_wr_data   (wr_data),
        .o_busy          (busy),
        .o_finish        (finish)
    );

    // pmem model with one-cycle read latency
    always @(posedge clk) begin
        if (rd_en0) d0 <= {pe_sel, 4'h0, rd_addr0};
        if (rd_en1) d1 <= {pe_sel, 4'hA, rd_addr1};
    end

    // DMA-side monitor
    always @(posedge clk) begin
        if (rd_en0) begin
            rd_n++;
            if (int'(pe_sel) > max_pe) max_pe = int'(pe_sel);
        end
        if (wr_en) en_n++;
        if (wr_en && ready) begin
            wr_n++;
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
        end
        if (finish) fin_n++;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int pe, input int a);
        logic [3:0] p;
        logic [7:0] ad;
        p  = pe[3:0];
        ad = a[7:0];
        return {p, 4'hA, ad, p, 4'h0, ad};
    endfunction

    task automatic clear_mon();
        wr_n = 0; en_n = 0; rd_n = 0; fin_n = 0; max_pe = 0;
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic run_job(
        input  logic [31:0] base,
        input  logic [8:0]  cnt,
        input  logic [4:0]  act,
        input  int          stall_at,
        input  int          stall_len,
        input  int          restart_at,
        input  logic [31:0] s_addr,
        input  logic [31:0] s_data,
        output int          f_cyc,
        output int          b_n,
        output int          s_n
    );
        int cyc = 0;
        clear_mon();
        base_addr = base;
        count_in  = cnt;
        pe_act_in = act;
        start     = 1'b1;
        f_cyc = 0; b_n = 0; s_n = 0;
        do begin
            @(negedge clk);
            cyc++;
            start = (cyc == restart_at);
            if (cyc == restart_at) count_in = 9'd0;
            ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
            if (busy) b_n++;
            if (cyc >= stall_at && cyc <= stall_at + stall_len &&
                wr_en && wr_addr == s_addr && wr_data == s_data &&
                pe_sel == 4'd0) s_n++;
            if (finish) f_cyc = cyc;
        end while (!finish && cyc < 20000);
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; ready = 1'b1;
        base_addr = '0; count_in = '0; pe_act_in = '0;
        d0 = '0; d1 = '0;
        clear_mon();
        #3;
        chk("reset_outs",
            {busy, finish, wr_en, rd_en0, rd_en1, pe_sel, rd_addr0},
            '0);
        chk("reset_wr", {wr_addr, wr_data}, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // 1: 2 PEs x 3 entries, ready high
        run_job(32'h1000, 9'd3, 5'd2, 0, 0, 0, 0, 0,
                fin_cyc, busy_n, stable_n);
        chk("t1_fin_cyc", fin_cyc, 19);
        chk("t1_busy", busy_n, 19);
        chk("t1_wr_n", wr_n, 6);
        chk("t1_rd_n", rd_n, 6);
        chk("t1_fin_n", fin_n, 1);
        for (int i = 0; i < 6; i++) begin
            if (i < wa_q.size()) begin
                chk($sformatf("t1_addr%0d", i), wa_q[i], 32'h1000 + 4 * i);
                chk($sformatf("t1_data%0d", i), wd_q[i], wd(i / 3, i % 3));
            end
        end
        chk("t1_idle_sel", {busy, pe_sel}, 0);

        // 2: ready low for 5 cycles on word 1
        run_job(32'h1000, 9'd3, 5'd2, 6, 5, 0, 32'h1004, wd(0, 1),
                fin_cyc, busy_n, stable_n);
        chk("t2_fin_cyc", fin_cyc, 24);
        chk("t2_stable", stable_n, 6);
        chk("t2_wr_n", wr_n, 6);
        if (wa_q.size() == 6) begin
            chk("t2_addr2", wa_q[2], 32'h1008);
            chk("t2_data5", wd_q[5], wd(1, 2));
        end

        // 3: empty jobs
        run_job(32'h1000, 9'd0, 5'd2, 0, 0, 0, 0, 0,
                fin_cyc, busy_n, stable_n);
        chk("t3a_fin_cyc", fin_cyc, 1);
        chk("t3a_busy", busy_n, 1);
        chk("t3a_rd_wr", {rd_n, en_n}, 0);
        run_job(32'h1000, 9'd3, 5'd0, 0, 0, 0, 0, 0,
                fin_cyc, busy_n, stable_n);
        chk("t3b_fin_cyc", fin_cyc, 1);
        chk("t3b_busy", busy_n, 1);
        chk("t3b_rd_wr", {rd_n, en_n}, 0);

        // 4a: start during WR is ignored
        run_job(32'h2000, 9'd2, 5'd1, 0, 0, 3, 0, 0,
                fin_cyc, busy_n, stable_n);
        chk("t4_fin_cyc", fin_cyc, 7);
        chk("t4_wr_n", wr_n, 2);
        chk("t4_fin_n", fin_n, 1);
        if (wa_q.size() == 2) chk("t4_addr1", wa_q[1], 32'h2004);

        // 4b: abort during WAIT
        clear_mon();
        base_addr = 32'h3000; count_in = 9'd3; pe_act_in = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_abort_idle", {busy, wr_en, finish}, 0);
        repeat (10) @(negedge clk);
        chk("t4_abort_quiet", {wr_n, en_n, fin_n}, 0);
        chk("t4_abort_rd", rd_n, 1);

        // 4c: clean restart after abort
        run_job(32'h4000, 9'd2, 5'd1, 0, 0, 0, 0, 0,
                fin_cyc, busy_n, stable_n);
        chk("t4c_fin_cyc", fin_cyc, 7);
        if (wa_q.size() == 2) begin
            chk("t4c_addr0", wa_q[0], 32'h4000);
            chk("t4c_data0", wd_q[0], wd(0, 0));
            chk("t4c_data1", wd_q[1], wd(0, 1));
        end

        // 5: async reset mid-WR
        clear_mon();
        base_addr = 32'h5000; count_in = 9'd3; pe_act_in = 5'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_in_wr", wr_en, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_outs",
            {busy, finish, wr_en, rd_en0, pe_sel, rd_addr0}, '0);
        chk("t5_rst_wr", {wr_addr, wr_data}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_idle", {busy, wr_en, finish}, 0);
        chk("t5_quiet", {en_n, fin_n}, 0);

        // 6: full array, address wrap
        run_job(32'hFFFF_FF00, 9'd256, 5'd16, 0, 0, 0, 0, 0,
                fin_cyc, busy_n, stable_n);
        chk("t6_fin_cyc", fin_cyc, 12289);
        chk("t6_wr_n", wr_n, 4096);
        chk("t6_fin_n", fin_n, 1);
        chk("t6_max_pe", max_pe, 15);
        if (wa_q.size() == 4096) begin
            chk("t6_addr63", wa_q[63], 32'hFFFF_FFFC);
            chk("t6_addr64", wa_q[64], 32'h0000_0000);
            chk("t6_data_last", wd_q[4095], wd(15, 255));
            chk("t6_data256", wd_q[256], wd(1, 0));
        end

        // 7: pe_act above array size clamps to 16
        run_job(32'h6000, 9'd1, 5'd20, 0, 0, 0, 0, 0,
                fin_cyc, busy_n, stable_n);
        chk("t7_wr_n", wr_n, 16);
        chk("t7_fin_cyc", fin_cyc, 49);
        if (wd_q.size() == 16) chk("t7_data15", wd_q[15], wd(15, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
